// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared FSM state encoding and default sizes for bus_arbiter (no ports)
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, OWN = 2'd2, RELEASE = 2'd3} state_e;
  localparam int NREQ_DEF = 4;
  localparam int WIDTH_DEF = 16;
  localparam int HOLD_MAX_DEF = 8;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant/data bundle; slave = arbiter side (req/rel/wr/data_in in; grant/grant_id/busy/oe/bus_out/timeout out), master = requester side
interface bus_arbiter_if import bus_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IW = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] rel;
  logic [NREQ-1:0] wr;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] grant_id;
  logic busy;
  logic oe;
  logic [WIDTH-1:0] bus_out;
  logic timeout;
  modport slave (input req, rel, wr, data_in, output grant, grant_id, busy, oe, bus_out, timeout);
  modport master (output req, rel, wr, data_in, input grant, grant_id, busy, oe, bus_out, timeout);
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, lowest offset from ptr wins; in req/ptr, out onehot/idx/any
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW-1:0] j;
  always_comb begin
    onehot = '0;
    idx = '0;
    j = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (req[j]) begin
        onehot = '0;
        onehot[j] = 1'b1;
        idx = j;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared transceiver bus with oe turnaround gaps; clk, reset (async active-low), bus_arbiter_if.slave bus; define BUS_ARB_TIMEOUT_EN for the HOLD_MAX watchdog
module bus_arbiter import bus_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  localparam int IW = $clog2(NREQ)
) (
  input logic clk,
  input logic reset,
  bus_arbiter_if.slave bus
);
  state_e state_q;
  logic [NREQ-1:0] grant_q, pick_oh;
  logic [IW-1:0] owner_q, ptr_q, ptr_d, pick_idx;
  logic busy_q, timeout_q, pick_any, own, oe, done, limit;
  if (NREQ < 2 || NREQ > 8 || HOLD_MAX < 1) begin : g_cfg
    $error("bus_arbiter: NREQ must be 2..8 and HOLD_MAX at least 1");
  end
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req),
    .ptr(ptr_q),
    .onehot(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign own = state_q == OWN;
  assign done = bus.rel[owner_q] || !bus.req[owner_q];
  assign ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q;
  assign limit = hold_q == HW'(HOLD_MAX - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) hold_q <= '0;
    else if (state_q == IDLE) hold_q <= '0;
    else if (own && hold_q != HW'(HOLD_MAX)) hold_q <= hold_q + 1'b1;
`else
  assign limit = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      busy_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (pick_any) begin
          state_q <= GRANT;
          grant_q <= pick_oh;
          owner_q <= pick_idx;
          busy_q <= 1'b1;
        end
        GRANT: state_q <= OWN;
        OWN: if (done || limit) begin
          state_q <= RELEASE;
          grant_q <= '0;
          busy_q <= 1'b0;
          ptr_q <= ptr_d;
          timeout_q <= !done;
        end
        RELEASE: state_q <= IDLE;
      endcase
    end
  assign oe = own && bus.wr[owner_q];
  assign bus.oe = oe;
  assign bus.bus_out = oe ? bus.data_in[owner_q*WIDTH +: WIDTH] : '0;
  assign bus.grant = grant_q;
  assign bus.grant_id = owner_q;
  assign bus.busy = busy_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table vectors plus hand sequences checked through an expectation queue against bus_arbiter
module tb_bus_arbiter;
  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic b;
    logic o;
    logic [15:0] bo;
    logic to;
    string nm;
  } exp_t;
  typedef struct {
    logic [3:0] rq;
    logic [3:0] rl;
    logic [3:0] w;
    exp_t e;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  logic [15:0] dat [4];
  vec_t vt [10];
  logic [3:0] oh;
  int o;
  bus_arbiter_if #(.NREQ(4), .WIDTH(16)) ifc ();
  bus_arbiter #(.NREQ(4), .WIDTH(16), .HOLD_MAX(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      checks++;
      if ({ifc.grant, ifc.busy, ifc.oe, ifc.bus_out, ifc.timeout} !== {cur.g, cur.b, cur.o, cur.bo, cur.to}
          || (cur.b && ifc.grant_id !== cur.id)) begin
        errors++;
        $display("FAIL %s: got grant=%b id=%0d busy=%b oe=%b bus_out=%h timeout=%b, want grant=%b id=%0d busy=%b oe=%b bus_out=%h timeout=%b",
                 cur.nm, ifc.grant, ifc.grant_id, ifc.busy, ifc.oe, ifc.bus_out, ifc.timeout,
                 cur.g, cur.id, cur.b, cur.o, cur.bo, cur.to);
      end
    end
  end
  task automatic step(input logic [3:0] rq, rl, w, g, input logic [1:0] id, input logic b, o_e,
                      input logic [15:0] bo, input logic to, input string nm);
    exp_t e;
    ifc.req = rq;
    ifc.rel = rl;
    ifc.wr = w;
    e = '{g, id, b, o_e, bo, to, nm};
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask
  task automatic check(input string nm, input logic [31:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    dat = '{16'hA5A5, 16'h0FF0, 16'h5A5A, 16'h3C3C};
    ifc.req = '0;
    ifc.rel = '0;
    ifc.wr = '0;
    ifc.data_in = {16'h3C3C, 16'h5A5A, 16'h0FF0, 16'hA5A5};
    vt = '{
      '{4'h1, 4'h0, 4'h1, '{4'h1, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0, "single grant"}},
      '{4'h1, 4'h0, 4'h1, '{4'h1, 2'd0, 1'b1, 1'b1, 16'hA5A5, 1'b0, "single own"}},
      '{4'h1, 4'h0, 4'h1, '{4'h1, 2'd0, 1'b1, 1'b1, 16'hA5A5, 1'b0, "single hold"}},
      '{4'h1, 4'h1, 4'h1, '{4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "single release"}},
      '{4'h0, 4'h0, 4'h0, '{4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "idle after release"}},
      '{4'h4, 4'h0, 4'h0, '{4'h4, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0, "read grant"}},
      '{4'h4, 4'h1, 4'h0, '{4'h4, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0, "read own"}},
      '{4'h5, 4'hB, 4'hB, '{4'h4, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0, "read own non-owner ignored"}},
      '{4'h0, 4'h0, 4'h0, '{4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "read req drop"}},
      '{4'h0, 4'h0, 4'h0, '{4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "read idle"}}
    };
    #1;
    check("reset outputs", 32'({ifc.grant, ifc.grant_id, ifc.busy, ifc.oe, ifc.bus_out, ifc.timeout}), 32'h0);
    #12 reset = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 10; i++)
      step(vt[i].rq, vt[i].rl, vt[i].w, vt[i].e.g, vt[i].e.id, vt[i].e.b, vt[i].e.o, vt[i].e.bo, vt[i].e.to, vt[i].e.nm);
    step(4'h2, 4'h0, 4'h2, 4'h2, 2'd1, 1'b1, 1'b0, 16'h0000, 1'b0, "pre-reset grant");
    step(4'h2, 4'h0, 4'h2, 4'h2, 2'd1, 1'b1, 1'b1, dat[1], 1'b0, "pre-reset own");
    reset = 1'b0;
    #1;
    check("async reset mid-OWN", 32'({ifc.grant, ifc.busy, ifc.oe, ifc.bus_out, ifc.timeout}), 32'h0);
    ifc.req = '0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      oh = 4'(1 << o);
      step(4'hF, 4'h0, 4'hF, oh, 2'(o), 1'b1, 1'b0, 16'h0000, 1'b0, "rr grant");
      step(4'hF, 4'h0, 4'hF, oh, 2'(o), 1'b1, 1'b1, dat[o], 1'b0, "rr own1");
      step(4'hF, 4'h0, 4'hF, oh, 2'(o), 1'b1, 1'b1, dat[o], 1'b0, "rr own2");
      step(4'hF, oh, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "rr release");
      step(4'hF, 4'h0, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "rr idle");
    end
    step(4'h6, 4'h0, 4'h2, 4'h2, 2'd1, 1'b1, 1'b0, 16'h0000, 1'b0, "wd grant");
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++)
      step(4'h6, 4'h0, 4'h2, 4'h2, 2'd1, 1'b1, 1'b1, dat[1], 1'b0, "wd own");
    step(4'h6, 4'h0, 4'h2, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b1, "wd forced release");
`else
    for (int i = 0; i < 12; i++)
      step(4'h6, 4'h0, 4'h2, 4'h2, 2'd1, 1'b1, 1'b1, dat[1], 1'b0, "wd own persists");
    step(4'h6, 4'h2, 4'h2, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "wd rel release");
`endif
    step(4'h6, 4'h0, 4'h2, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "wd idle");
    step(4'h6, 4'h0, 4'h2, 4'h4, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0, "pending req2 grant");
    step(4'h4, 4'h0, 4'h2, 4'h4, 2'd2, 1'b1, 1'b0, 16'h0000, 1'b0, "req2 read own");
    step(4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "req2 drop release");
    step(4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "req2 idle");
    step(4'h1, 4'h0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0, "lim grant");
    for (int i = 0; i < 8; i++)
      step(4'h1, 4'h0, 4'h1, 4'h1, 2'd0, 1'b1, 1'b1, dat[0], 1'b0, "lim own");
    step(4'h1, 4'h1, 4'h1, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "rel at limit");
    step(4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, "lim idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the CPU's single 16-bit bidirectional I/O bus (the `transceiver` path) between up to NREQ requesters: CPU core, timer service logic and peripherals. It grants exactly one owner at a time and muxes that owner's write data onto the transceiver `in` port. It drives the transceiver `oe` with one-cycle turnaround gaps on both sides of every ownership, so two drivers never overlap on `bidir`.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `WIDTH`, 16: bus data width
- `HOLD_MAX`, 8: maximum cycles one owner may stay in OWN (watchdog limit)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `req`  in  NREQ  per-requester bus request, level
- `rel`  in  NREQ  per-requester release strobe, one cycle
- `wr`  in  NREQ  per-requester direction: 1 = requester drives bus
- `data_in`  in  NREQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
- `grant`  out  NREQ  one-hot grant, registered
- `grant_id`  out  $clog2(NREQ)  index of current owner, valid while `busy`
- `busy`  out  1  any grant active (GRANT or OWN)
- `oe`  out  1  transceiver output enable
- `bus_out`  out  WIDTH  data to transceiver `in`
- `timeout`  out  1  one-cycle pulse on watchdog forced release

## Operation
- FSM states: IDLE, GRANT, OWN, RELEASE.
- IDLE: if any `req` is set, pick a winner round-robin, starting the search at `ptr`. Load `owner`, set `grant[owner]`, go to GRANT. Stay in IDLE if no `req` is set.
- GRANT: exactly one cycle, `oe`=0 (turnaround); then go to OWN.
- OWN: `oe` = `wr[owner]`; `bus_out` = `data_in[owner]`. The hold counter increments each cycle.
- OWN exits to RELEASE when `rel[owner]`=1 or `req[owner]`=0, or, with the watchdog compiled in, when the hold counter reaches HOLD_MAX.
- RELEASE: `grant`=0, `oe`=0, `bus_out`=0 for one cycle. `ptr` = owner+1, wrapping at NREQ-1 → 0. Then go to IDLE.
- Requests and releases from non-owners are ignored during GRANT/OWN/RELEASE. A non-owner's `req` stays pending and is served in IDLE.
- If `rel[owner]` and the watchdog limit occur in the same cycle, it is a normal release and `timeout` stays 0.
- `bus_out` = 0 and `oe` = 0 in every state except OWN.
- The hold counter is $clog2(HOLD_MAX+1) bits wide, clears on entry to GRANT, and saturates at HOLD_MAX.

## Timing
- Reset (`reset`=0) forces, immediately and asynchronously: state IDLE, `grant`=0, `grant_id`=0, `busy`=0, `oe`=0, `bus_out`=0, `timeout`=0, `ptr`=0, hold counter 0. Reset mid-OWN drops `oe` without any turnaround cycle.
- Request to grant: `req` high before edge n → `grant` high after edge n.
- `oe` rises after edge n+1, the first OWN cycle.
- Release: `rel` sampled at edge m → `grant`/`oe` low after edge m (RELEASE). IDLE follows after edge m+1. The next grant appears after edge m+2 at the earliest.
- Back-to-back handover: 3 cycles minimum between the two owners' OWN states, with at least 2 cycles of `oe`=0.
- `timeout` pulses during the RELEASE cycle that follows a forced exit.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined: the hold counter and HOLD_MAX watchdog are active. An owner is forced out after HOLD_MAX OWN cycles and `timeout` pulses.
- `BUS_ARB_TIMEOUT_EN` undefined: no hold counter is instantiated, `timeout` is tied 0, and ownership lasts until `rel` or the owner's `req` drops.

## Structure
- Shared package `bus_arb_pkg` holds the state encoding constants (IDLE=2'd0, GRANT=2'd1, OWN=2'd2, RELEASE=2'd3) and the default WIDTH/HOLD_MAX constants.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot winner, winner index, `any`.
- `bus_arbiter` contains only the FSM, registers, hold counter and data mux.

## Test plan
- Single request: `req`=0001, `wr`=0001, `data_in[0]`=16'hA5A5.
  - `grant`=0001 one cycle later.
  - `oe`=1 and `bus_out`=A5A5 from the following cycle.
  - `rel[0]` → `grant`=0 and `oe`=0 the next cycle.
- Round-robin fairness: `req`=1111 held continuously, each owner pulses `rel` on its second OWN cycle → grant order 0,1,2,3,0 with 3-cycle handovers.
- Read owner: `req`=0100, `wr`=0000 → `grant`=0100 with `oe`=0 and `bus_out`=0 throughout OWN.
- Watchdog (macro defined, HOLD_MAX=8): `req[1]` held, never released → forced RELEASE after 8 OWN cycles, `timeout` one-cycle pulse, then `req[2]` served if pending. With the macro undefined, the grant persists indefinitely.
- Simultaneous `rel[owner]` and limit reached → release with `timeout`=0.
- Reset pulse (`reset`=0) mid-OWN with `oe`=1 → `oe`, `grant`, `busy` go to 0 without waiting for a clock edge. After release of reset, `req`=1111 grants requester 0 first.
